// File: rtl/riscv_mem_bram_responder_pkg.sv
// Shared types and constants for the BRAM-backed memory responder.
// Holds the controller state encoding and the legal read-latency range.
package riscv_mem_bram_responder_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

endpackage

// File: rtl/riscv_mem_bram_array.sv
// Single-port synchronous RAM: one write or one read per cycle, registered read data.
// Contents have no reset; the owner clears them with a sweep after reset.
module riscv_mem_bram_array #(
  parameter int DATA_W     = 128,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/riscv_mem_bram_responder.sv
// Memory responder: zero-fills its RAM after reset, then serves tagged reads with a
// fixed READ_LAT latency and untracked writes, with range checking and access counters.
module riscv_mem_bram_responder
  import riscv_mem_bram_responder_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 26,
  parameter int TAG_W      = 5,
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req_val,
  output logic              mem_req_rdy,
  input  logic              mem_req_rw,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [DATA_W-1:0] mem_req_data,
  input  logic [TAG_W-1:0]  mem_req_tag,
  output logic              mem_resp_val,
  output logic [DATA_W-1:0] mem_resp_data,
  output logic [TAG_W-1:0]  mem_resp_tag,
  output logic              addr_error,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output state_t            dbg_state
);

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
    $error("READ_LAT out of legal range");
  end

  // Handshake: a request transfers on a rising edge with mem_req_val && mem_req_rdy;
  // mem_req_rdy is a function of state only. Responses have no backpressure.
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DEPTH_LOG2-1:0]   r_index;
  logic                    w_accept;
  logic                    w_oor;
  logic                    w_rd_acc;
  logic                    w_ram_we;
  logic                    w_ram_re;
  logic [DEPTH_LOG2-1:0]   w_ram_addr;
  logic [DATA_W-1:0]       w_ram_wdata;
  logic [DATA_W-1:0]       w_ram_rdata;
  logic [DATA_W-1:0]       w_data_aligned;

  logic [READ_LAT-1:0]             r_pv;
  logic [READ_LAT-1:0]             r_poor;
  logic [READ_LAT-1:0][TAG_W-1:0]  r_ptag;
  logic                            r_resp_val;
  logic [DATA_W-1:0]               r_resp_data;
  logic [TAG_W-1:0]                r_resp_tag;
  logic                            r_addr_error;
  logic [31:0]                     r_rd_count;
  logic [31:0]                     r_wr_count;

  assign w_oor    = |mem_req_addr[ADDR_W-1:DEPTH_LOG2];
  assign w_accept = mem_req_val & mem_req_rdy;
  assign w_rd_acc = w_accept & ~mem_req_rw;

  always_comb begin
    w_state_nxt = r_state;
    mem_req_rdy = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = mem_req_addr[DEPTH_LOG2-1:0];
    w_ram_wdata = mem_req_data;
    case (r_state)
      ST_INIT: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_index;
        w_ram_wdata = '0;
        if (r_index == '1) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        mem_req_rdy = 1'b1;
        // Out-of-range requests never touch the array.
        if (mem_req_val && !w_oor) begin
          w_ram_we = mem_req_rw;
          w_ram_re = ~mem_req_rw;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_index <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_index <= r_index + 1'b1;
      end
    end
  end

  riscv_mem_bram_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // RAM data is valid one cycle after acceptance; delay it to line up with r_pv's last stage.
  if (READ_LAT == 1) begin : g_no_dpipe
    assign w_data_aligned = w_ram_rdata;
  end else begin : g_dpipe
    logic [READ_LAT-2:0][DATA_W-1:0] r_dpipe;
    always_ff @(posedge clk) begin
      r_dpipe[0] <= w_ram_rdata;
      for (int k = 1; k < READ_LAT - 1; k++) begin
        r_dpipe[k] <= r_dpipe[k-1];
      end
    end
    assign w_data_aligned = r_dpipe[READ_LAT-2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv         <= '0;
      r_poor       <= '0;
      r_ptag       <= '0;
      r_resp_val   <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
      r_addr_error <= 1'b0;
      r_rd_count   <= '0;
      r_wr_count   <= '0;
    end else begin
      r_pv[0]   <= w_rd_acc;
      r_poor[0] <= w_oor;
      r_ptag[0] <= mem_req_tag;
      for (int k = 1; k < READ_LAT; k++) begin
        r_pv[k]   <= r_pv[k-1];
        r_poor[k] <= r_poor[k-1];
        r_ptag[k] <= r_ptag[k-1];
      end
      r_resp_val <= r_pv[READ_LAT-1];
      if (r_pv[READ_LAT-1]) begin
        r_resp_tag  <= r_ptag[READ_LAT-1];
        r_resp_data <= r_poor[READ_LAT-1] ? '0 : w_data_aligned;
      end
      if (w_accept) begin
        if (mem_req_rw) r_wr_count <= r_wr_count + 32'd1;
        else            r_rd_count <= r_rd_count + 32'd1;
        if (w_oor) r_addr_error <= 1'b1;
      end
    end
  end

  assign mem_resp_val  = r_resp_val;
  assign mem_resp_data = r_resp_data;
  assign mem_resp_tag  = r_resp_tag;
  assign addr_error    = r_addr_error;
  assign rd_count      = r_rd_count;
  assign wr_count      = r_wr_count;
  assign dbg_state     = r_state;

endmodule

// File: doc/riscv_mem_bram_responder.md
RISCV_MEM_BRAM_RESPONDER -- requirements
Module: riscv_mem_bram_responder

Interface
REQ-001 Parameter DATA_W, default 128: width of one memory word, in bits.
REQ-002 Parameter ADDR_W, default 26: width of the word address, in bits.
REQ-003 Parameter TAG_W, default 5: width of the request/response tag, in bits.
REQ-004 Parameter DEPTH_LOG2, default 12: the block stores 2^DEPTH_LOG2 words.
REQ-005 Parameter READ_LAT, default 2, legal range 1..4: cycles from read acceptance to mem_resp_val.
REQ-006 Port clk, input, 1 bit: single clock; all state is clocked on its rising edge.
REQ-007 Port rst_n, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-008 Port mem_req_val, input, 1 bit: the initiator presents a request.
REQ-009 Port mem_req_rdy, output, 1 bit: the block can accept a request this cycle.
REQ-010 Port mem_req_rw, input, 1 bit: 1 = write, 0 = read.
REQ-011 Port mem_req_addr, input, ADDR_W bits: word address.
REQ-012 Port mem_req_data, input, DATA_W bits: write data.
REQ-013 Port mem_req_tag, input, TAG_W bits: tag returned with the read response.
REQ-014 Port mem_resp_val, output, 1 bit: read response valid; the initiator always accepts it (no ready).
REQ-015 Port mem_resp_data, output, DATA_W bits: read data.
REQ-016 Port mem_resp_tag, output, TAG_W bits: tag of the originating read.
REQ-017 Port addr_error, output, 1 bit: sticky flag set by an out-of-range access.
REQ-018 Port rd_count and wr_count, outputs, 32 bits each: counts of accepted reads and accepted writes.

Function
REQ-019 The controller has two states. INIT: mem_req_rdy=0 and an index counter writes zero to word 0..2^DEPTH_LOG2-1, one word per cycle. READY: mem_req_rdy=1.
REQ-020 The controller moves from INIT to READY in the cycle after the last word is cleared, so READY is reached 2^DEPTH_LOG2 cycles after rst_n deasserts.
REQ-021 A request is accepted on a rising edge where mem_req_val and mem_req_rdy are both 1; mem_req_rdy does not depend combinationally on mem_req_val.
REQ-022 A write updates the word at mem_req_addr[DEPTH_LOG2-1:0] at the acceptance edge; no response is produced; wr_count increments.
REQ-023 An accepted read produces exactly one response with mem_resp_val=1, exactly READ_LAT cycles after acceptance, carrying the same tag; rd_count increments.
REQ-024 Reads may be issued back-to-back, one per cycle; responses return in request order with no gaps added.
REQ-025 Read-after-write ordering: a read accepted any number of cycles after a write to the same address returns the written data, including a read accepted on the very next cycle.
REQ-026 A request with any set bit in mem_req_addr[ADDR_W-1:DEPTH_LOG2] is out of range; such a write is dropped, such a read returns all-zero data with its tag, and either case sets addr_error.
REQ-027 Out-of-range requests are still counted in rd_count or wr_count.
REQ-028 rd_count and wr_count wrap from 0xFFFFFFFF to 0.
REQ-029 mem_resp_data and mem_resp_tag hold their last value while mem_resp_val=0.

Reset
REQ-030 Asserting rst_n low, including during INIT or while reads are in flight, immediately forces state=INIT, index=0, all read-pipeline valid bits to 0, mem_resp_val=0, mem_req_rdy=0, addr_error=0, rd_count=0, wr_count=0, mem_resp_tag=0, and mem_resp_data=0.
REQ-031 Reads in flight when reset asserts are discarded and never produce a response.
REQ-032 Memory contents are not reset asynchronously; they are cleared by the INIT sweep that follows every reset.

Structure
REQ-033 The state enum (INIT, READY) and the READ_LAT legal-range constants belong in the shared memif package.
REQ-034 One sub-module, riscv_mem_bram_array, holds the single-port synchronous RAM (one write or one read per cycle, registered read output).
REQ-035 The read pipeline that aligns valid, tag and out-of-range flag to READ_LAT is a shift register in the top module.

Verification
REQ-036 Deassert rst_n, then poll mem_req_rdy -> it rises exactly 4096 cycles later; a read of address 0x123 then returns 128'h0.
REQ-037 Write 0xDEADBEEF to addr 0x10, then read addr 0x10 with tag 7 on the next cycle -> response 2 cycles later with data 0xDEADBEEF, tag 7, and wr_count=1, rd_count=1.
REQ-038 Issue 4 back-to-back reads with tags 1,2,3,4 -> 4 consecutive response cycles carrying tags 1,2,3,4 in order.
REQ-039 Read addr 0x1000 (out of range at DEPTH_LOG2=12) with tag 9 -> response carries data 0 and tag 9, and addr_error=1 stays set.
REQ-040 Pull rst_n low one cycle after accepting a read -> no mem_resp_val pulse appears and all outputs read 0.
REQ-041 Preload wr_count to 0xFFFFFFFF via force, then perform one write -> wr_count=0.
